// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: CPU bridge bus shared with the LED light driver
interface seg7_scan_driver_if;
  logic        Addr;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] RD;
  modport master(output Addr, DIn, WE, input RD);
  modport slave(input Addr, DIn, WE, output RD);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: memory-mapped 8-digit common-anode hex display scanner with blank gap per slot
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 500,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  seg7_scan_driver_if.slave         bus,
  output logic [7:0]                digit_sel,
  output logic [7:0]                seg
);
  localparam logic [15:0][6:0] HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [31:0]      data;
  logic [16:0]      ctrl;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             en, dark;
  logic [3:0]       nib;
  logic [7:0]       blank, dp;
  assign en    = ctrl[16];
  assign blank = ctrl[7:0];
  assign dp    = ctrl[15:8];
  assign nib   = data[{idx, 2'b00} +: 4];
  assign dark  = !en || cnt < CNT_W'(GAP_CYCLES) || blank[idx];
  assign bus.RD = reset ? '0 : bus.Addr ? {15'd0, ctrl} : data;
  always_ff @(posedge clk) begin
    if (reset) begin
      data      <= '0;
      ctrl      <= 17'h1_0000;
      cnt       <= '0;
      idx       <= '0;
      digit_sel <= 8'hFF;
      seg       <= 8'hFF;
    end else begin
      if (bus.WE && bus.Addr) ctrl <= bus.DIn[16:0];
      if (bus.WE && !bus.Addr) data <= bus.DIn;
      // scan state uses the pre-write enable, so a disabling write darkens one edge later
      if (!en) begin
        cnt <= '0;
        idx <= '0;
      end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      digit_sel <= dark ? 8'hFF : ~(8'd1 << idx);
      seg       <= dark ? 8'hFF : {~dp[idx], HEX[nib]};
    end
  end
endmodule
